// File: rtl/bitstream_counter.sv
// Counts ones in a 2^LENGTH_LOG2-cycle window of a stochastic bitstream and presents
// the scaled count with a valid/ready handshake. Define BITSTREAM_COUNTER_BIPOLAR_EN for bipolar output.
module bitstream_counter #(
    parameter int LENGTH_LOG2 = 16,  // must be >= OUT_WIDTH
    parameter int OUT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 x,
    input  logic                 ready,
    output logic                 busy,
    output logic                 valid,
    output logic [OUT_WIDTH-1:0] result
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] COUNT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam int SHIFT = LENGTH_LOG2 - OUT_WIDTH;
    localparam logic [LENGTH_LOG2:0] SAT_MAX =
        {{(LENGTH_LOG2 + 1 - OUT_WIDTH){1'b0}}, {OUT_WIDTH{1'b1}}};

    logic [1:0]             state;
    logic [LENGTH_LOG2:0]   ones_cnt;
    logic [LENGTH_LOG2-1:0] win_cnt;
    logic [LENGTH_LOG2:0]   final_count;
    logic [LENGTH_LOG2:0]   shifted;
    logic [OUT_WIDTH-1:0]   sat_value;
    logic [OUT_WIDTH-1:0]   result_next;

    // Count including the sample taken on the current edge, so the last sample is not lost.
    assign final_count = ones_cnt + (LENGTH_LOG2 + 1)'(x);
    assign shifted     = final_count >> SHIFT;
    // Only an all-ones window exceeds the output range after scaling.
    assign sat_value   = (shifted > SAT_MAX) ? {OUT_WIDTH{1'b1}} : shifted[OUT_WIDTH-1:0];

    always_comb begin
        // NOTE: give every always_comb output a default first so no path can infer a latch.
        result_next = sat_value;
`ifdef BITSTREAM_COUNTER_BIPOLAR_EN
        result_next[OUT_WIDTH-1] = ~sat_value[OUT_WIDTH-1];
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ones_cnt <= '0;
            win_cnt  <= '0;
            busy     <= 1'b0;
            valid    <= 1'b0;
            result   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= COUNT;
                        ones_cnt <= '0;
                        win_cnt  <= '0;
                        busy     <= 1'b1;
                    end
                end
                COUNT: begin
                    ones_cnt <= final_count;
                    win_cnt  <= win_cnt + LENGTH_LOG2'(1);
                    if (&win_cnt) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        valid  <= 1'b1;
                        result <= result_next;
                    end
                end
                DONE: begin
                    if (ready) begin
                        valid <= 1'b0;
                        // Back-to-back: a start on the accepting edge skips IDLE.
                        if (start) begin
                            state    <= COUNT;
                            ones_cnt <= '0;
                            win_cnt  <= '0;
                            busy     <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitstream_counter.sv
// Self-checking bench for bitstream_counter: table-driven streams, randomized streams
// against a counting model, and hand-written handshake/reset sequences.
module tb_bitstream_counter;

`ifdef BITSTREAM_COUNTER_BIPOLAR_EN
    localparam bit BIP = 1'b1;
`else
    localparam bit BIP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, x8, ready8, busy8, valid8;
    logic [7:0] result8;
    logic       start10, x10, ready10, busy10, valid10;
    logic [7:0] result10;

    bitstream_counter #(.LENGTH_LOG2(8), .OUT_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .x(x8), .ready(ready8),
        .busy(busy8), .valid(valid8), .result(result8)
    );

    bitstream_counter #(.LENGTH_LOG2(10), .OUT_WIDTH(8)) dut10 (
        .clk(clk), .rst(rst), .start(start10), .x(x10), .ready(ready10),
        .busy(busy10), .valid(valid10), .result(result10)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int mode;     // 0 all zeros, 1 all ones, 2 alternating 1,0
        int log2;
        int exp_res;
    } vec_t;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Reference: fraction of ones rescaled to 8 bits, clipped at full scale.
    function automatic int ref_result(input int ones, input int log2);
        int q;
        q = ones / (1 << (log2 - 8));
        if (q > 255) q = 255;
        if (BIP) q = q ^ 128;
        return q;
    endfunction

    task automatic drive(input bit which, input logic s, input logic xv, input logic r);
        if (which) begin start10 = s; x10 = xv; ready10 = r; end
        else       begin start8  = s; x8  = xv; ready8  = r; end
    endtask

    function automatic int get_busy(input bit which);
        return which ? int'(busy10) : int'(busy8);
    endfunction
    function automatic int get_valid(input bit which);
        return which ? int'(valid10) : int'(valid8);
    endfunction
    function automatic int get_result(input bit which);
        return which ? int'(result10) : int'(result8);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kick(input bit which);
        drive(which, 1'b1, 1'b0, 1'b0);
        tick();
        drive(which, 1'b0, 1'b0, 1'b0);
    endtask

    // Feeds one full window; assumes the start edge has just passed.
    task automatic window(input bit which, input int log2, input int mode, input int density,
                          input bit pulse_start, output int ones);
        int n;
        int busy_cycles;
        logic b;
        n = 1 << log2;
        ones = 0;
        busy_cycles = get_busy(which);
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       b = 1'b0;
                1:       b = 1'b1;
                2:       b = (i % 2 == 0);
                default: b = ($urandom_range(0, 99) < density);
            endcase
            ones += int'(b);
            drive(which, pulse_start && (i == n / 2), b, 1'b0);
            tick();
            if (i < n - 1) busy_cycles += get_busy(which);
            if (i == n - 2) check("valid low before last sample", get_valid(which), 0);
        end
        drive(which, 1'b0, 1'b0, 1'b0);
        check("busy cycle count", busy_cycles, n);
        check("busy low at window end", get_busy(which), 0);
        check("valid high at window end", get_valid(which), 1);
    endtask

    task automatic handshake(input bit which, input int exp_res);
        drive(which, 1'b0, 1'b0, 1'b1);
        tick();
        drive(which, 1'b0, 1'b0, 1'b0);
        check("valid low after handshake", get_valid(which), 0);
        check("result held after handshake", get_result(which), exp_res);
    endtask

    initial begin
        vec_t vecs[4];
        int ones;
        int exp_res;
        bit which;

        vecs[0] = '{mode: 0, log2: 8,  exp_res: BIP ? 'h80 : 'h00};
        vecs[1] = '{mode: 1, log2: 8,  exp_res: BIP ? 'h7F : 'hFF};
        vecs[2] = '{mode: 2, log2: 8,  exp_res: BIP ? 'h00 : 'h80};
        vecs[3] = '{mode: 2, log2: 10, exp_res: BIP ? 'h00 : 'h80};

        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        check("reset busy", int'(busy8), 0);
        check("reset valid", int'(valid8), 0);
        check("reset result", int'(result8), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            which = (vecs[i].log2 == 10);
            kick(which);
            check("busy after start edge", get_busy(which), 1);
            window(which, vecs[i].log2, vecs[i].mode, 0, 1'b0, ones);
            check($sformatf("vector %0d result", i), get_result(which), vecs[i].exp_res);
            handshake(which, vecs[i].exp_res);
        end

        for (int i = 0; i < 6; i++) begin
            int density;
            which = (i == 5);
            density = (i == 0) ? 100 : (i == 1) ? 0 : int'($urandom_range(0, 100));
            kick(which);
            window(which, which ? 10 : 8, 3, density, 1'b0, ones);
            exp_res = ref_result(ones, which ? 10 : 8);
            check($sformatf("random %0d result", i), get_result(which), exp_res);
            handshake(which, exp_res);
        end

        // Start pulse mid-COUNT is ignored, then DONE holds with ready low for 50 cycles.
        exp_res = BIP ? 'h00 : 'h80;
        kick(1'b0);
        window(1'b0, 8, 2, 0, 1'b1, ones);
        check("result with start pulse in COUNT", int'(result8), exp_res);
        for (int c = 0; c < 50; c++) begin
            drive(1'b0, (c == 10) || (c == 30), 1'b0, 1'b0);
            tick();
            check("valid held in DONE", int'(valid8), 1);
            check("result held in DONE", int'(result8), exp_res);
            check("start ignored in DONE", int'(busy8), 0);
        end

        // Back-to-back: ready and start together in DONE.
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check("b2b valid dropped", int'(valid8), 0);
        check("b2b busy", int'(busy8), 1);
        window(1'b0, 8, 1, 0, 1'b0, ones);
        exp_res = BIP ? 'h7F : 'hFF;
        check("b2b second result", int'(result8), exp_res);

        // Reset mid-DONE-then-COUNT: abort at sample 100, outputs clear without an edge.
        handshake(1'b0, exp_res);
        kick(1'b0);
        for (int i = 0; i < 100; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0);
            tick();
        end
        #2 rst = 1'b1;
        #1;
        check("async reset busy", int'(busy8), 0);
        check("async reset valid", int'(valid8), 0);
        check("async reset result", int'(result8), 0);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        kick(1'b0);
        window(1'b0, 8, 2, 0, 1'b0, ones);
        check("full window after reset", int'(result8), BIP ? 'h00 : 'h80);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
